dds_sine_noise_src: RTL and testbench
=====================================

Name: dds_sine_noise_src

Overview:
- Upstream sample source for the IIR DF1 biquad; drives its 16-bit signed `din`.
- Generates a sine wave with a phase-accumulator DDS and a quarter-wave LUT.
- Optionally adds LFSR pseudo-random noise, with a saturating add.
- Produces one sample per sample tick, for in-system filter testing without a file-fed bench.

Parameters:
- PHASE_W, 32: phase accumulator width.
- LUT_ADDR_W, 8: quarter-wave LUT address width; N = 2^LUT_ADDR_W entries.
- AMP, 30000: peak LUT amplitude.
- NOISE_SHIFT, 4: arithmetic right shift applied to the LFSR word before it is added.
- CLK_DIV, 1: clocks per sample tick; must be ≥ 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; ticks occur only while high.
- tune_word  in  PHASE_W  phase increment per sample; sampled on each tick.
- noise_en  in  1  add noise; sampled on each tick.
- dout  out  16  signed sample to the biquad `din`.
- dout_valid  out  1  one-cycle pulse marking a new `dout`.

Behaviour:
- **Reset (synchronous, active-high):**
  - phase=0, div_cnt=0, lfsr=16'hACE1.
  - All pipeline valid bits = 0, dout=0, dout_valid=0.
  - Reset mid-stream discards in-flight samples; no dout_valid until a new tick completes the pipeline.
- **Divider:**
  - When en=1, div_cnt counts 0..CLK_DIV-1 and wraps.
  - tick = en & (div_cnt == CLK_DIV-1).
  - When en=0, div_cnt holds and no ticks occur. The pipeline still drains, so in-flight samples emerge.
- **Stage 1 (on tick):**
  - Capture the current phase and the current lfsr into s1.
  - Update phase <= phase + tune_word, mod 2^PHASE_W.
  - Advance lfsr (Galois, right shift): if lsb=1, lfsr <= (lfsr>>1) ^ 16'hB400; else lfsr <= lfsr>>1.
  - Latch noise_en. Set s1_valid.
  - The sample therefore uses the pre-increment phase.
- **Stage 2: address generation.**
  - q = phase[PHASE_W-1:PHASE_W-2].
  - idx = next LUT_ADDR_W bits below q.
  - addr = idx for q=0 and q=2; addr = ~idx for q=1 and q=3.
  - neg = q[1].
- **Stage 3: registered LUT read.**
  - LUT[k] = round(AMP·sin(π/2·(k+0.5)/N)), k=0..N-1, computed at elaboration.
  - Value = neg ? -LUT[addr] : LUT[addr].
- **Stage 4: output.**
  - Noise term = noise_en_latched ? ($signed(lfsr_s1) >>> NOISE_SHIFT) : 0.
  - Sum in 18-bit signed, then saturate to [-32768, 32767].
  - Register dout; pulse dout_valid for 1 cycle.
- **Latency:** dout/dout_valid update on the 3rd rising edge after the edge that sampled tick=1. This gives full throughput at CLK_DIV=1.
- **Between pulses:** dout holds its last value.
- **tune_word=0:** constant output of LUT[0] (with noise if enabled).
- **Wrap-around:** phase wraps silently.

Test Plan:
1. Reset with en=1, tune_word=0, noise_en=0:
   - During reset, and 1 cycle after it releases → dout=0, dout_valid=0.
   - First dout_valid on the 3rd edge after the first tick, then every cycle, with dout=92 constant.
2. tune_word=2^30, noise_en=0, CLK_DIV=1 → dout repeats 92, 30000, -92, -30000 on consecutive cycles.
3. tune_word=0, noise_en=1:
   - First two samples → -1238 (92-1330), then -381 (92-473).
   - This confirms the LFSR seed 16'hACE1 and the sequence 16'hE270.
4. CLK_DIV=4, tune_word=2^30:
   - dout_valid pulses exactly every 4th cycle with the same 4-value sequence.
   - Dropping en for 10 cycles → pulses stop after in-flight samples drain; the sequence resumes without skipping a phase.
5. Saturation: AMP=32767, NOISE_SHIFT=0, tune_word=2^30, noise_en=1:
   - 6th sample = 32767, saturated from 32767+3623.
   - Samples 1–5 = -21178, 25199, 28883, -18275, 7347.
6. Assert rst for 1 cycle while samples are in flight (tune_word=2^30):
   - No dout_valid for 3 cycles after rst deasserts.
   - Next sample = 92 (phase restarted at 0).

Source files
------------

// File: rtl/dds_sine_noise_src_if.sv
// Sample-source bus: run/tuning controls in, 16-bit signed samples out.
interface dds_sine_noise_src_if #(
  parameter int PHASE_W = 32
);
  logic               en;
  logic [PHASE_W-1:0] tune_word;
  logic               noise_en;
  logic signed [15:0] dout;
  logic               dout_valid;

  // Controller side: drives the controls, consumes the samples.
  modport master (
    output en,
    output tune_word,
    output noise_en,
    input  dout,
    input  dout_valid
  );

  // Generator side.
  modport slave (
    input  en,
    input  tune_word,
    input  noise_en,
    output dout,
    output dout_valid
  );
endinterface

// File: rtl/dds_sine_noise_src.sv
// DDS sine source with optional LFSR noise, feeding a biquad input.
// Phase accumulator + quarter-wave LUT, 4-stage pipeline from tick to dout.
module dds_sine_noise_src #(
  parameter int PHASE_W     = 32,
  parameter int LUT_ADDR_W  = 8,
  parameter int AMP         = 30000,
  parameter int NOISE_SHIFT = 4,
  parameter int CLK_DIV     = 1
) (
  input logic                 clk,
  input logic                 rst,
  dds_sine_noise_src_if.slave src_if
);

  localparam int          N         = 1 << LUT_ADDR_W;
  localparam int          DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int          TOP_W     = LUT_ADDR_W + 2;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  if (CLK_DIV < 1) begin : g_bad_div
    $error("CLK_DIV must be at least 1");
  end
  if (PHASE_W < TOP_W) begin : g_bad_phase
    $error("PHASE_W must cover the quadrant and LUT index bits");
  end

  // Taylor series for sin(x), x in [0, pi/2]; only used at elaboration.
  function automatic real sin_series(input real x);
    real term;
    real sum;
    term = x;
    sum  = x;
    for (int n = 1; n < 14; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  // Quarter-wave entry k, sampled at bin centres so the table is symmetric.
  function automatic int lut_entry(input int k);
    real x;
    x = 3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(N);
    return $rtoi(real'(AMP) * sin_series(x) + 0.5);
  endfunction

  // Noise contribution: sign-extended LFSR word, arithmetically scaled down.
  function automatic logic signed [17:0] noise_term(input logic [15:0] lfsr,
                                                    input logic        nen);
    logic signed [17:0] w;
    w = $signed({{2{lfsr[15]}}, lfsr});
    return nen ? (w >>> NOISE_SHIFT) : 18'sd0;
  endfunction

  // Clamp an 18-bit sum into the 16-bit signed output range.
  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767) begin
      return 16'sh7FFF;
    end
    if (v < -18'sd32768) begin
      return 16'sh8000;
    end
    return $signed(v[15:0]);
  endfunction

  logic signed [15:0] lut_rom [N];

  for (genvar k = 0; k < N; k++) begin : g_lut
    localparam int LV = lut_entry(k);
    assign lut_rom[k] = 16'(LV);
  end

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic               tick;

  logic               vld_p1_q, vld_p2_q, vld_p3_q;
  logic [TOP_W-1:0]   ph_p1_q;
  logic [15:0]        lfsr_p1_q;
  logic               nen_p1_q;

  logic [1:0]            quad_p1;
  logic [LUT_ADDR_W-1:0] idx_p1;
  logic [LUT_ADDR_W-1:0] addr_p2_q;
  logic                  neg_p2_q;
  logic signed [17:0]    noise_p2_q;

  logic signed [15:0] lut_p3_q;
  logic signed [17:0] noise_p3_q;
  logic signed [17:0] sum_p3;

  logic signed [15:0] dout_q, dout_d;
  logic               dout_valid_q;

  assign tick = src_if.en && (div_cnt_q == DIV_W'(CLK_DIV - 1));

  // Divider, phase accumulator and LFSR advance only while enabled.
  always_comb begin
    div_cnt_d = div_cnt_q;
    phase_d   = phase_q;
    lfsr_d    = lfsr_q;
    if (src_if.en) begin
      div_cnt_d = (div_cnt_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_cnt_q + 1'b1;
    end
    if (tick) begin
      phase_d = phase_q + src_if.tune_word;
      lfsr_d  = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
    end
  end

  // Control state: counters, generators, valid chain and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q    <= '0;
      phase_q      <= '0;
      lfsr_q       <= LFSR_SEED;
      vld_p1_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
      vld_p3_q     <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      phase_q      <= phase_d;
      lfsr_q       <= lfsr_d;
      vld_p1_q     <= tick;
      vld_p2_q     <= vld_p1_q;
      vld_p3_q     <= vld_p2_q;
      dout_valid_q <= vld_p3_q;
      dout_q       <= dout_d;
    end
  end

  // Stage 1: snapshot the pre-increment phase, current LFSR and noise enable.
  always_ff @(posedge clk) begin
    if (tick) begin
      ph_p1_q   <= phase_q[PHASE_W-1 -: TOP_W];
      lfsr_p1_q <= lfsr_q;
      nen_p1_q  <= src_if.noise_en;
    end
  end

  assign quad_p1 = ph_p1_q[TOP_W-1 -: 2];
  assign idx_p1  = ph_p1_q[LUT_ADDR_W-1:0];

  // Stage 2: fold the phase onto the quarter wave (mirror in quadrants 1 and 3).
  always_ff @(posedge clk) begin
    addr_p2_q  <= quad_p1[0] ? ~idx_p1 : idx_p1;
    neg_p2_q   <= quad_p1[1];
    noise_p2_q <= noise_term(lfsr_p1_q, nen_p1_q);
  end

  // Stage 3: registered LUT read with sign restored for the lower half-wave.
  always_ff @(posedge clk) begin
    lut_p3_q   <= neg_p2_q ? -lut_rom[addr_p2_q] : lut_rom[addr_p2_q];
    noise_p3_q <= noise_p2_q;
  end

  // Stage 4: widened add of sine and noise, then clamp; hold between samples.
  assign sum_p3 = $signed({{2{lut_p3_q[15]}}, lut_p3_q}) + noise_p3_q;
  assign dout_d = vld_p3_q ? sat16(sum_p3) : dout_q;

  assign src_if.dout       = dout_q;
  assign src_if.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_dds_sine_noise_src.sv
// Bench for dds_sine_noise_src: three parameterisations share one stimulus
// stream; a sample-level reference model plus directed golden sequences.
module tb_dds_sine_noise_src;

  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] tune;
  logic        nen;
  logic        chk_on;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dds_sine_noise_src_if #(.PHASE_W(32)) bus_a ();
  dds_sine_noise_src_if #(.PHASE_W(32)) bus_b ();
  dds_sine_noise_src_if #(.PHASE_W(32)) bus_c ();

  assign bus_a.en = en;  assign bus_a.tune_word = tune;  assign bus_a.noise_en = nen;
  assign bus_b.en = en;  assign bus_b.tune_word = tune;  assign bus_b.noise_en = nen;
  assign bus_c.en = en;  assign bus_c.tune_word = tune;  assign bus_c.noise_en = nen;

  dds_sine_noise_src #(.PHASE_W(32), .LUT_ADDR_W(8), .AMP(30000), .NOISE_SHIFT(4), .CLK_DIV(1))
    dut_a (.clk(clk), .rst(rst), .src_if(bus_a));
  dds_sine_noise_src #(.PHASE_W(32), .LUT_ADDR_W(8), .AMP(30000), .NOISE_SHIFT(4), .CLK_DIV(4))
    dut_b (.clk(clk), .rst(rst), .src_if(bus_b));
  dds_sine_noise_src #(.PHASE_W(32), .LUT_ADDR_W(8), .AMP(32767), .NOISE_SHIFT(0), .CLK_DIV(1))
    dut_c (.clk(clk), .rst(rst), .src_if(bus_c));

  logic dv [3];
  int   dd [3];
  assign dv[0] = bus_a.dout_valid;  assign dd[0] = int'(bus_a.dout);
  assign dv[1] = bus_b.dout_valid;  assign dd[1] = int'(bus_b.dout);
  assign dv[2] = bus_c.dout_valid;  assign dd[2] = int'(bus_c.dout);

  int amp  [3] = '{30000, 30000, 32767};
  int nsh  [3] = '{4, 4, 0};
  int cdiv [3] = '{1, 4, 1};
  int q4   [4] = '{92, 30000, -92, -30000};
  int sat6 [6] = '{-21178, 25199, 28883, -18275, 7347, 32767};

  task automatic check_val(input string tag, input int got, input int exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: each tick yields a sample directly from the sine of the
  // phase position; it appears at the output three edges later.
  int unsigned m_phase [3];
  logic [15:0] m_lfsr  [3];
  int          m_div   [3];
  logic        m_pv    [3][3];
  int          m_pd    [3][3];
  logic        m_vld   [3];
  int          m_dout  [3];
  int          cyc_n = 0;

  function automatic int ref_sample(input int i);
    int  p, mag, s, noise, sum;
    real sv;
    p   = int'(m_phase[i] >> 22);
    sv  = $sin(2.0 * PI * (real'(p) + 0.5) / 1024.0);
    mag = $rtoi(real'(amp[i]) * ((sv < 0.0) ? -sv : sv) + 0.5);
    s   = (sv < 0.0) ? -mag : mag;
    noise = nen ? (int'($signed(m_lfsr[i])) >>> nsh[i]) : 0;
    sum = s + noise;
    if (sum > 32767)  sum = 32767;
    if (sum < -32768) sum = -32768;
    return sum;
  endfunction

  always @(posedge clk) begin
    cyc_n = cyc_n + 1;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_phase[i] = 0;
        m_lfsr[i]  = 16'hACE1;
        m_div[i]   = 0;
        m_vld[i]   = 1'b0;
        m_dout[i]  = 0;
        for (int k = 0; k < 3; k++) m_pv[i][k] = 1'b0;
      end else begin
        m_vld[i] = m_pv[i][2];
        if (m_pv[i][2]) m_dout[i] = m_pd[i][2];
        m_pv[i][2] = m_pv[i][1];  m_pd[i][2] = m_pd[i][1];
        m_pv[i][1] = m_pv[i][0];  m_pd[i][1] = m_pd[i][0];
        m_pv[i][0] = 1'b0;
        if (en) begin
          if (m_div[i] == cdiv[i] - 1) begin
            m_div[i]   = 0;
            m_pv[i][0] = 1'b1;
            m_pd[i][0] = ref_sample(i);
            m_phase[i] = m_phase[i] + tune;
            m_lfsr[i]  = m_lfsr[i][0] ? ((m_lfsr[i] >> 1) ^ 16'hB400) : (m_lfsr[i] >> 1);
          end else begin
            m_div[i] = m_div[i] + 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        check_val($sformatf("model_valid%0d", i), int'(dv[i]), int'(m_vld[i]));
        check_val($sformatf("model_dout%0d", i), dd[i], m_dout[i]);
      end
    end
  end

  // Sample capture for the directed sequences.
  int cap  [3][128];
  int capc [3][128];
  int ncap [3] = '{0, 0, 0};

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      if (dv[i] && ncap[i] < 128) begin
        cap[i][ncap[i]]  = dd[i];
        capc[i][ncap[i]] = cyc_n;
        ncap[i]          = ncap[i] + 1;
      end
    end
  end

  task automatic clr_cap();
    for (int i = 0; i < 3; i++) ncap[i] = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic restart();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; tune = 32'd0; nen = 1'b0; chk_on = 1'b0;
    cyc(1);
    chk_on = 1'b1;
    cyc(2);
    check_val("rst_dout", dd[0], 0);
    check_val("rst_valid", int'(dv[0]), 0);

    // Constant tone at tune_word=0.
    clr_cap();
    rst = 1'b0;
    cyc(1);
    check_val("t1_post_rst_valid", int'(dv[0]), 0);
    check_val("t1_post_rst_dout", dd[0], 0);
    cyc(2);
    check_val("t1_latency", ncap[0], 0);
    cyc(1);
    check_val("t1_first_valid", int'(dv[0]), 1);
    check_val("t1_first_dout", dd[0], 92);
    cyc(7);
    check_val("t1_count", ncap[0], 8);
    for (int k = 0; k < ncap[0]; k++) check_val("t1_const", cap[0][k], 92);

    // Quarter-cycle steps.
    restart();
    tune = 32'h4000_0000;
    clr_cap();
    cyc(10);
    check_val("t2_count", ncap[0], 7);
    for (int k = 0; k < ncap[0]; k++) check_val("t2_seq", cap[0][k], q4[k % 4]);

    // LFSR seed and first advance.
    restart();
    tune = 32'd0; nen = 1'b1;
    clr_cap();
    cyc(5);
    check_val("t3_count", ncap[0], 2);
    check_val("t3_noise0", cap[0][0], -1238);
    check_val("t3_noise1", cap[0][1], -381);

    // Divided tick rate, pause and resume.
    restart();
    tune = 32'h4000_0000; nen = 1'b0;
    clr_cap();
    cyc(40);
    check_val("t4_count", ncap[1], 9);
    for (int k = 0; k < 8; k++) check_val("t4_spacing", capc[1][k+1] - capc[1][k], 4);
    en = 1'b0;
    cyc(10);
    en = 1'b1;
    cyc(40);
    check_val("t4_total", ncap[1], 19);
    for (int k = 0; k < ncap[1]; k++) check_val("t4_seq", cap[1][k], q4[k % 4]);

    // Saturating add on the full-scale instance.
    restart();
    tune = 32'h4000_0000; nen = 1'b1;
    clr_cap();
    cyc(9);
    check_val("t5_count", ncap[2], 6);
    for (int k = 0; k < 6; k++) check_val("t5_sat_seq", cap[2][k], sat6[k]);

    // Reset with samples in flight.
    nen = 1'b0;
    cyc(5);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    clr_cap();
    cyc(3);
    check_val("t6_flushed", ncap[0], 0);
    cyc(1);
    check_val("t6_count", ncap[0], 1);
    check_val("t6_restart", cap[0][0], 92);

    // Randomized controls against the model.
    for (int it = 0; it < 2500; it++) begin
      int r;
      r   = int'($urandom_range(0, 199));
      rst = (r < 2);
      en  = (r >= 20);
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0: tune = $urandom;
          1: tune = 32'h4000_0000;
          2: tune = 32'd0;
          default: tune = $urandom_range(0, 32'h00FF_FFFF);
        endcase
      end
      nen = ($urandom_range(0, 1) == 1);
      cyc(1);
    end
    rst = 1'b0; en = 1'b1;
    cyc(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
